resp_checker: RTL and testbench

- Synthesizable response checker: the receiving end of a stimulus-driving bench.
- Stimulus source pushes expected vectors into an internal FIFO. The DUT output stream arrives on a valid/ready port.
- Block compares each actual word against the oldest expected word, counts mismatches, records the first failure and compresses all actual words into a MISR signature.
- Used in self-checking simulation and on-board tests of datapath units (MUX/ALU/register-file slices).

---
 rtl/resp_checker_pkg.sv | 13 +
 rtl/resp_checker_sync_fifo.sv | 52 +++++
 rtl/resp_checker.sv | 108 ++++++++++
 tb/tb_resp_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resp_checker_pkg.sv
// Shared definitions for the response checker and its helpers.
package resp_chk_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] DEF_POLY = 8'h1D;
    localparam logic [7:0] DEF_SEED = 8'hFF;

endpackage

// File: rtl/resp_checker_sync_fifo.sv
// Synchronous FIFO with a combinational head read.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/resp_checker.sv
// Compares a DUT output stream against queued expected words,
// tracks mismatches and folds every actual word into a MISR.
module resp_checker
    import resp_chk_defs::*;
#(
    parameter int           W     = 8,
    parameter int           DEPTH = 16,
    parameter logic [W-1:0] POLY  = W'(DEF_POLY),
    parameter logic [W-1:0] SEED  = W'(DEF_SEED)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [15:0]  total,
    input  logic         exp_valid,
    input  logic [W-1:0] exp_data,
    output logic         exp_ready,
    input  logic         act_valid,
    input  logic [W-1:0] act_data,
    output logic         act_ready,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  err_cnt,
    output logic [15:0]  chk_cnt,
    output logic [15:0]  first_idx,
    output logic [W-1:0] first_exp,
    output logic [W-1:0] first_act,
    output logic [W-1:0] signature
);

    state_t       state;
    state_t       state_nxt;
    logic [15:0]  total_q;
    logic [W-1:0] head;
    logic         full;
    logic         empty;
    logic         fire;
    logic         restart;
    logic [W-1:0] sig_nxt;

    sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (exp_valid),
        .pop   (fire),
        .din   (exp_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign exp_ready = !full;
    assign act_ready = (state == RUN) && !empty;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign pass      = done && (err_cnt == '0);
    assign fire      = act_valid && act_ready;
    assign restart   = start && (state != RUN);

    always_comb begin
        sig_nxt = {signature[W-2:0], 1'b0} ^ act_data;
        if (signature[W-1]) sig_nxt = sig_nxt ^ POLY;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) state_nxt = (total == '0) ? DONE : RUN;
            end
            RUN: begin
                if (fire && (chk_cnt + 16'd1 == total_q)) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // err_cnt saturates, so a zero count means no mismatch yet this run.
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            total_q   <= rst_n ? total : '0;
            err_cnt   <= '0;
            chk_cnt   <= '0;
            first_idx <= '0;
            first_exp <= '0;
            first_act <= '0;
            signature <= SEED;
        end else if (fire) begin
            chk_cnt   <= chk_cnt + 16'd1;
            signature <= sig_nxt;
            if (act_data != head) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (err_cnt == '0) begin
                    first_idx <= chk_cnt;
                    first_exp <= head;
                    first_act <= act_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_resp_checker.sv
// Randomized and directed bench for resp_checker against a queue model.
module tb_resp_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] total;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_ready;
    logic        act_valid;
    logic [7:0]  act_data;
    logic        act_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_cnt;
    logic [15:0] chk_cnt;
    logic [15:0] first_idx;
    logic [7:0]  first_exp;
    logic [7:0]  first_act;
    logic [7:0]  signature;

    int total_n = 0;
    int bad_n   = 0;

    resp_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .total     (total),
        .exp_valid (exp_valid),
        .exp_data  (exp_data),
        .exp_ready (exp_ready),
        .act_valid (act_valid),
        .act_data  (act_data),
        .act_ready (act_ready),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .chk_cnt   (chk_cnt),
        .first_idx (first_idx),
        .first_exp (first_exp),
        .first_act (first_act),
        .signature (signature)
    );

    always #5 clk = ~clk;

    // Behavioural model
    logic [7:0]  q[$];
    bit          m_ok = 0;
    bit          m_run;
    bit          m_done;
    int          m_total;
    int          m_err;
    int          m_chk;
    int          m_fidx;
    logic [7:0]  m_fexp;
    logic [7:0]  m_fact;
    logic [7:0]  m_sig;

    function automatic logic [7:0] misr(logic [7:0] s, logic [7:0] d);
        logic [7:0] r;
        r = {s[6:0], 1'b0};
        if (s[7]) r = r ^ 8'h1D;
        return r ^ d;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total_n++;
        if (got !== want) begin
            bad_n++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(posedge clk) begin
        bit         do_push;
        bit         do_pop;
        logic [7:0] d;
        if (!rst_n) begin
            q.delete();
            m_ok = 1;
            m_run = 0; m_done = 0; m_total = 0;
            m_err = 0; m_chk = 0; m_fidx = 0;
            m_fexp = 0; m_fact = 0; m_sig = 8'hFF;
        end else if (m_ok) begin
            d       = exp_data;
            do_push = exp_valid && q.size() < 16;
            do_pop  = act_valid && m_run && q.size() > 0;
            if (do_pop) begin
                if (act_data != q[0]) begin
                    if (m_err == 0) begin
                        m_fidx = m_chk; m_fexp = q[0]; m_fact = act_data;
                    end
                    if (m_err < 65535) m_err++;
                end
                m_chk++;
                m_sig = misr(m_sig, act_data);
                void'(q.pop_front());
                if (m_chk == m_total) begin
                    m_run = 0; m_done = 1;
                end
            end else if (start && !m_run) begin
                m_total = total;
                m_err = 0; m_chk = 0; m_fidx = 0;
                m_fexp = 0; m_fact = 0; m_sig = 8'hFF;
                m_run = (total != 0);
                m_done = (total == 0);
            end
            if (do_push) q.push_back(d);
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("exp_ready", exp_ready, q.size() < 16);
            check("act_ready", act_ready, m_run && q.size() > 0);
            check("busy", busy, m_run);
            check("done", done, m_done);
            check("pass", pass, m_done && m_err == 0);
            check("err_cnt", err_cnt, m_err);
            check("chk_cnt", chk_cnt, m_chk);
            check("first_idx", first_idx, m_fidx);
            check("first_exp", first_exp, m_fexp);
            check("first_act", first_act, m_fact);
            check("signature", signature, m_sig);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(logic [7:0] d);
        exp_valid = 1; exp_data = d;
        cyc();
        exp_valid = 0;
    endtask

    task automatic go(int n);
        start = 1; total = 16'(n);
        cyc();
        start = 0;
    endtask

    task automatic reset_dut();
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    task automatic send(logic [7:0] d);
        act_valid = 1; act_data = d;
        cyc();
        act_valid = 0;
    endtask

    logic [7:0] words[40];
    logic [7:0] v4[4];

    initial begin
        int pushed;
        int n;
        rst_n = 0; start = 0; total = 0;
        exp_valid = 0; exp_data = 0;
        act_valid = 0; act_data = 0;
        cyc(); cyc();
        rst_n = 1;
        check("rst_sig", signature, 8'hFF);
        check("rst_busy", busy, 0);

        check("misr_ff_00", misr(8'hFF, 8'h00), 8'hE3);
        check("misr_00_5a", misr(8'h00, 8'h5A), 8'h5A);

        // Matching run
        v4[0] = 8'h11; v4[1] = 8'h22; v4[2] = 8'h33; v4[3] = 8'h44;
        for (int i = 0; i < 4; i++) push_word(v4[i]);
        go(4);
        for (int i = 0; i < 4; i++) send(v4[i]);
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_err", err_cnt, 0);
        check("t1_chk", chk_cnt, 4);

        // One mismatch on the third word
        for (int i = 0; i < 4; i++) push_word(v4[i]);
        go(4);
        send(8'h11); send(8'h22); send(8'h30); send(8'h44);
        check("t2_err", err_cnt, 1);
        check("t2_fidx", first_idx, 2);
        check("t2_fexp", first_exp, 8'h33);
        check("t2_fact", first_act, 8'h30);
        check("t2_pass", pass, 0);

        // Signature of a single zero word
        push_word(8'h00);
        go(1);
        send(8'h00);
        check("t3_sig", signature, 8'hE3);

        // Fill, overflow, then streaming across pointer wrap
        for (int i = 0; i < 40; i++) words[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 16; i++) push_word(words[i]);
        check("t4_full", exp_ready, 0);
        push_word(8'hEE);
        check("t4_refused", q.size(), 16);
        pushed = 16;
        go(40);
        n = 0;
        while (!done && n < 2000) begin
            exp_valid = pushed < 40 && q.size() < 16 && $urandom_range(0, 3) != 0;
            exp_data  = words[pushed % 40];
            act_valid = $urandom_range(0, 3) != 0;
            act_data  = q.size() > 0 ? q[0] : 8'h00;
            cyc();
            if (exp_valid) pushed++;
            n++;
        end
        exp_valid = 0; act_valid = 0;
        check("t4_done", done, 1);
        check("t4_pass", pass, 1);
        check("t4_chk", chk_cnt, 40);

        // Zero-length run, then stray act_valid
        push_word(8'hA1); push_word(8'hA2);
        go(0);
        check("t5_done", done, 1);
        check("t5_pass", pass, 1);
        act_valid = 1; act_data = 8'hA1;
        cyc(); cyc();
        act_valid = 0;
        check("t5_chk", chk_cnt, 0);
        check("t5_q", q.size(), 2);

        // Reset mid-run
        reset_dut();
        for (int i = 0; i < 4; i++) push_word(v4[i]);
        go(4);
        send(v4[0]); send(8'h00);
        check("t6_mid_chk", chk_cnt, 2);
        reset_dut();
        check("t6_busy", busy, 0);
        check("t6_err", err_cnt, 0);
        check("t6_chk", chk_cnt, 0);
        check("t6_fexp", first_exp, 0);
        check("t6_sig", signature, 8'hFF);
        check("t6_empty", exp_ready, 1);
        go(1);
        check("t6_act_ready", act_ready, 0);

        // Randomized runs with injected mismatches and stray starts
        for (int r = 0; r < 4; r++) begin
            reset_dut();
            go($urandom_range(20, 30));
            n = 0;
            while (!done && n < 1000) begin
                exp_valid = $urandom_range(0, 2) != 0;
                exp_data  = 8'($urandom);
                act_valid = $urandom_range(0, 2) != 0;
                act_data  = (q.size() > 0 && $urandom_range(0, 4) != 0)
                            ? q[0] : 8'($urandom);
                start     = $urandom_range(0, 19) == 0;
                total     = 16'($urandom_range(1, 5));
                cyc();
                n++;
            end
            exp_valid = 0; act_valid = 0; start = 0;
            check("t7_done", done, 1);
        end

        cyc();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
